// File: rtl/fifo_mst_xfer_if.sv
// ---------------------------------------------------------------------------
// fifo_mst_xfer_if
//  Bundles every non-clock/reset signal of the FT600 FIFO-master transfer
//  engine:
//   - the arbiter handshake: grant, t_ep_num, m_rd_wr, idle_st
//   - the FT600 bus: ft_rxf_n, ft_txe_n, ft_data_i/o, ft_data_oe, the strobes
//   - the per-channel memory port: mem_ep, FWFT read side, write side
//   - burst status: xfer_done, xfer_len
//  modport master : the transfer engine's view.
//  modport slave  : the environment's view (arbiter, FT600, memory).
// ---------------------------------------------------------------------------
interface fifo_mst_xfer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
);
  // arbiter handshake
  logic              grant;
  logic [2:0]        t_ep_num;
  logic              m_rd_wr;
  logic              idle_st;
  // FT600 bus
  logic              ft_rxf_n;
  logic              ft_txe_n;
  logic [DATA_W-1:0] ft_data_i;
  logic [DATA_W-1:0] ft_data_o;
  logic              ft_data_oe;
  logic              ft_wr_n;
  logic              ft_rd_n;
  logic              ft_oe_n;
  // memory port
  logic [2:0]        mem_ep;
  logic              mem_rd_vld;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_en;
  logic              mem_wr_rdy;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  // burst status
  logic              xfer_done;
  logic [CNT_W-1:0]  xfer_len;

  modport master (
    input  grant, t_ep_num, m_rd_wr,
    output idle_st,
    input  ft_rxf_n, ft_txe_n, ft_data_i,
    output ft_data_o, ft_data_oe, ft_wr_n, ft_rd_n, ft_oe_n,
    output mem_ep,
    input  mem_rd_vld, mem_rd_data,
    output mem_rd_en,
    input  mem_wr_rdy,
    output mem_wr_en, mem_wr_data,
    output xfer_done, xfer_len
  );

  modport slave (
    output grant, t_ep_num, m_rd_wr,
    input  idle_st,
    output ft_rxf_n, ft_txe_n, ft_data_i,
    input  ft_data_o, ft_data_oe, ft_wr_n, ft_rd_n, ft_oe_n,
    input  mem_ep,
    output mem_rd_vld, mem_rd_data,
    input  mem_rd_en,
    output mem_wr_rdy,
    input  mem_wr_en, mem_wr_data,
    input  xfer_done, xfer_len
  );
endinterface

// File: rtl/fifo_mst_xfer.sv
// ---------------------------------------------------------------------------
// fifo_mst_xfer
//  FT600 FIFO-master transfer engine. After a grant from the arbiter it runs
//  one command word plus one data burst on the FT600 bus for the granted
//  channel, moving words between the bus and the local per-channel memory,
//  then pulses xfer_done with the burst length and returns to idle.
// Ports
//  fifoClk : single clock, all logic on the rising edge
//  fifoRst : asynchronous active-high reset
//  bus     : fifo_mst_xfer_if.master (arbiter handshake, FT600 bus,
//            memory port, burst status)
// Parameters
//  DATA_W    : bus / memory word width
//  BURST_MAX : maximum words per burst; the word counter is
//              $clog2(BURST_MAX+1) bits so it can hold BURST_MAX itself
// ---------------------------------------------------------------------------
module fifo_mst_xfer #(
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 1024
) (
  input  logic            fifoClk,
  input  logic            fifoRst,
  fifo_mst_xfer_if.master bus
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_TURN = 3'd2,
    ST_RD   = 3'd3,
    ST_WR   = 3'd4,
    ST_END  = 3'd5
  } state_e;

  state_e           state_q,      state_d;
  logic [2:0]       ep_q,         ep_d;
  logic             dir_q,        dir_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] xfer_len_q,   xfer_len_d;
  logic             xfer_done_q,  xfer_done_d;
  logic             idle_st_q,    idle_st_d;
  logic             ft_oe_n_q,    ft_oe_n_d;
  logic             data_oe_q,    data_oe_d;
  logic             cmd_stb_q,    cmd_stb_d;

  logic             rd_beat_s;
  logic             wr_beat_s;
  logic             last_beat_s;

  // A data beat needs the engine in the data phase and both the FT600 and the
  // memory side ready in the same cycle.
  assign rd_beat_s   = (state_q == ST_RD) & ~bus.ft_rxf_n & bus.mem_wr_rdy;
  assign wr_beat_s   = (state_q == ST_WR) & ~bus.ft_txe_n & bus.mem_rd_vld;
  // Beat that brings the count up to BURST_MAX; it is still taken, then exit.
  assign last_beat_s = (rd_beat_s | wr_beat_s) & (cnt_q == CNT_LAST);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ep_d       = ep_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    xfer_len_d = xfer_len_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.grant && (bus.t_ep_num != 3'd0)) begin
          state_d = ST_CMD;
          ep_d    = bus.t_ep_num;
          dir_d   = bus.m_rd_wr;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (dir_q) begin
          state_d = ST_TURN;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_TURN: begin
        state_d = ST_RD;
      end
      ST_RD: begin
        if (rd_beat_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (bus.ft_rxf_n || !bus.mem_wr_rdy || last_beat_s) begin
          state_d = ST_END;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (wr_beat_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (bus.ft_txe_n || !bus.mem_rd_vld || last_beat_s) begin
          state_d = ST_END;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The length is captured on entry to END so it is valid with xfer_done.
    if (state_d == ST_END) begin
      xfer_len_d = cnt_d;
    end else begin
      xfer_len_d = xfer_len_q;
    end

    // State-decoded outputs are computed from the next state so they come
    // straight out of flops in the cycle the state is entered.
    idle_st_d   = (state_d == ST_IDLE);
    xfer_done_d = (state_d == ST_END);
    ft_oe_n_d   = ~((state_d == ST_TURN) || (state_d == ST_RD));
    data_oe_d   = (state_d == ST_CMD) || (state_d == ST_WR);
    cmd_stb_d   = (state_d == ST_CMD);
  end

  // State and output registers; reset aborts any burst with no done pulse.
  always_ff @(posedge fifoClk or posedge fifoRst) begin
    if (fifoRst) begin
      state_q     <= ST_IDLE;
      ep_q        <= 3'd0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      xfer_len_q  <= '0;
      xfer_done_q <= 1'b0;
      idle_st_q   <= 1'b1;
      ft_oe_n_q   <= 1'b1;
      data_oe_q   <= 1'b0;
      cmd_stb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ep_q        <= ep_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      xfer_len_q  <= xfer_len_d;
      xfer_done_q <= xfer_done_d;
      idle_st_q   <= idle_st_d;
      ft_oe_n_q   <= ft_oe_n_d;
      data_oe_q   <= data_oe_d;
      cmd_stb_q   <= cmd_stb_d;
    end
  end

  // Command word: direction in bit 3, channel in bits 2:0. In the write data
  // phase the FWFT head word is passed straight to the bus.
  always_comb begin
    if (cmd_stb_q) begin
      bus.ft_data_o = {{(DATA_W-4){1'b0}}, dir_q, ep_q};
    end else if (state_q == ST_WR) begin
      bus.ft_data_o = bus.mem_rd_data;
    end else begin
      bus.ft_data_o = '0;
    end
  end

  // Data-phase strobes follow the same-cycle handshakes, so they are
  // combinational on top of the registered state.
  assign bus.ft_wr_n     = ~(cmd_stb_q | wr_beat_s);
  assign bus.ft_rd_n     = ~((state_q == ST_RD) & bus.mem_wr_rdy);
  assign bus.ft_oe_n     = ft_oe_n_q;
  assign bus.ft_data_oe  = data_oe_q;
  assign bus.idle_st     = idle_st_q;
  assign bus.mem_ep      = ep_q;
  assign bus.mem_rd_en   = wr_beat_s;
  assign bus.mem_wr_en   = rd_beat_s;
  assign bus.mem_wr_data = bus.ft_data_i;
  assign bus.xfer_done   = xfer_done_q;
  assign bus.xfer_len    = xfer_len_q;

endmodule
